// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the parametrised CRC encoder:
//   - FSM state encodings (S_IDLE / S_SHIFT / S_DONE)
//   - default generator polynomial and LFSR seed
//   - crcSteps(): number of LFSR cycles needed to fold one payload word
// No ports (package).
// ---------------------------------------------------------------------------
package crc_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // x^4 + x + 1 with the implicit x^4 term dropped
  localparam logic [3:0] CRC_DEFAULT_POLY = 4'h3;
  localparam logic [3:0] CRC_DEFAULT_INIT = 4'h0;

  // Cycles spent in SHIFT for one word
  function automatic int crcSteps(input int dataW, input int bitsPerStep);
    return dataW / bitsPerStep;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// ---------------------------------------------------------------------------
// crc_lfsr_step
// Combinational fold of BITS_PER_STEP payload bits into a CRC register,
// MSB first, using a Galois-style LFSR update.
// Ports:
//   crc_i   in   CRC_W           current CRC value
//   bits_i  in   BITS_PER_STEP   payload bits, bits_i[BITS_PER_STEP-1] first
//   crc_o   out  CRC_W           CRC after folding all bits_i
// ---------------------------------------------------------------------------
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int              CRC_W         = 4,
  parameter int              BITS_PER_STEP = 1,
  parameter logic [CRC_W-1:0] POLY         = CRC_W'(CRC_DEFAULT_POLY)
) (
  input  logic [CRC_W-1:0]         crc_i,
  input  logic [BITS_PER_STEP-1:0] bits_i,
  output logic [CRC_W-1:0]         crc_o
);

  // Unrolled chain: each bit sees the CRC left behind by the previous bit
  always_comb begin
    logic [CRC_W-1:0] crcAcc;
    logic             fb;
    crcAcc = crc_i;
    fb     = 1'b0;
    for (int i = BITS_PER_STEP - 1; i >= 0; i--) begin
      fb     = bits_i[i] ^ crcAcc[CRC_W-1];
      crcAcc = {crcAcc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_o = crcAcc;
  end

endmodule

// File: rtl/crc_param_encoder.sv
// ---------------------------------------------------------------------------
// crc_param_encoder
// Accepts a payload + address on a write strobe, folds the payload through a
// CRC LFSR BITS_PER_STEP bits per cycle (MSB first), then presents
// {payload, crc} and the address to the memory write port with a one-cycle
// data_valid pulse.
// Optional feature macro: CRC_ENC_INBUF_EN adds a one-entry input buffer so
// a new word can be accepted while the current one is still being encoded.
// Ports:
//   clk         in   1              clock, rising edge
//   rst         in   1              asynchronous reset, active low
//   write       in   1              write request
//   data_in     in   DATA_W         payload
//   addr_in     in   ADDR_W         target address
//   busy        out  1              a write this cycle will be ignored
//   data_valid  out  1              data_out/addr_out valid (one-cycle pulse)
//   data_out    out  DATA_W+CRC_W   {payload, crc}
//   addr_out    out  ADDR_W         address of data_out
// ---------------------------------------------------------------------------
module crc_param_encoder
  import crc_pkg::*;
#(
  parameter int               DATA_W        = 8,
  parameter int               CRC_W         = 4,
  parameter logic [CRC_W-1:0] POLY          = CRC_W'(CRC_DEFAULT_POLY),
  parameter logic [CRC_W-1:0] CRC_INIT      = CRC_W'(CRC_DEFAULT_INIT),
  parameter int               ADDR_W        = 4,
  parameter int               BITS_PER_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [ADDR_W-1:0]       addr_in,
  output logic                    busy,
  output logic                    data_valid,
  output logic [DATA_W+CRC_W-1:0] data_out,
  output logic [ADDR_W-1:0]       addr_out
);

  localparam int STEPS = crcSteps(DATA_W, BITS_PER_STEP);
  localparam int CNT_W = $clog2(STEPS + 1);

  if ((DATA_W % BITS_PER_STEP) != 0) begin : g_bad_step
    $error("BITS_PER_STEP must divide DATA_W");
  end

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CRC_W-1:0]        crc_q;
  logic [DATA_W-1:0]       data_q;
  logic [DATA_W-1:0]       shift_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    valid_q;
  logic [DATA_W+CRC_W-1:0] dataOut_q;
  logic [ADDR_W-1:0]       addrOut_q;
  logic [CRC_W-1:0]        crcNext;

  logic                    load;
  logic [DATA_W-1:0]       loadData;
  logic [ADDR_W-1:0]       loadAddr;

  crc_lfsr_step #(
    .CRC_W        (CRC_W),
    .BITS_PER_STEP(BITS_PER_STEP),
    .POLY         (POLY)
  ) u_step (
    .crc_i (crc_q),
    .bits_i(shift_q[DATA_W-1 -: BITS_PER_STEP]),
    .crc_o (crcNext)
  );

`ifdef CRC_ENC_INBUF_EN
  logic              bufValid_q;
  logic [DATA_W-1:0] bufData_q;
  logic [ADDR_W-1:0] bufAddr_q;
  logic              bufCapture;
  logic              bufRelease;
`endif

  // Next-state logic. 'load' starts a new word from whichever source
  // (host write or buffered word) is selected for this cycle.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    loadData = data_in;
    loadAddr = addr_in;
`ifdef CRC_ENC_INBUF_EN
    bufCapture = 1'b0;
    bufRelease = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (write) load = 1'b1;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = S_DONE;
`ifdef CRC_ENC_INBUF_EN
        if (write && !bufValid_q) bufCapture = 1'b1;
`endif
      end
      S_DONE: begin
`ifdef CRC_ENC_INBUF_EN
        // Buffered word has priority; a write now is ignored (busy is high)
        if (bufValid_q) begin
          load       = 1'b1;
          loadData   = bufData_q;
          loadAddr   = bufAddr_q;
          bufRelease = 1'b1;
        end else if (write) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (load) state_d = S_SHIFT;
  end

  // Word registers and LFSR. The shift copy feeds the step from its MSB
  // end so the original payload stays intact for data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      data_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q  <= loadData;
        shift_q <= loadData;
        addr_q  <= loadAddr;
        crc_q   <= CRC_INIT;
        cnt_q   <= '0;
      end else if (state_q == S_SHIFT) begin
        crc_q   <= crcNext;
        shift_q <= shift_q << BITS_PER_STEP;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Output registers: only DONE updates them, so they hold between words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      dataOut_q <= '0;
      addrOut_q <= '0;
    end else begin
      valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        dataOut_q <= {data_q, crc_q};
        addrOut_q <= addr_q;
      end
    end
  end

`ifdef CRC_ENC_INBUF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bufValid_q <= 1'b0;
      bufData_q  <= '0;
      bufAddr_q  <= '0;
    end else if (bufRelease) begin
      bufValid_q <= 1'b0;
    end else if (bufCapture) begin
      bufValid_q <= 1'b1;
      bufData_q  <= data_in;
      bufAddr_q  <= addr_in;
    end
  end

  assign busy = bufValid_q;
`else
  assign busy = (state_q != S_IDLE);
`endif

  assign data_valid = valid_q;
  assign data_out   = dataOut_q;
  assign addr_out   = addrOut_q;

endmodule
